uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 67 ++++++
 tb/tb_uart_tx_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter merging two framed byte streams into one UART TX FIFO
module uart_tx_arbiter #(
    parameter int DBIT    = 8,
    parameter int MAX_LEN = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0_valid,
    input  logic [DBIT-1:0] req0_data,
    input  logic            req0_last,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [DBIT-1:0] req1_data,
    input  logic            req1_last,
    output logic            req1_ready,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [1:0]      grant,
    output logic            busy,
    output logic            frame_cut
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t     state, state_next;
    logic       ptr, ptr_next;
    logic [7:0] cnt, cnt_next;
    logic       cut, cut_next;
    logic       xfer, own_last, at_max, rel;

    // owner state, round-robin pointer, per-grant byte count and cut pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
            cnt   <= 8'd0;
            cut   <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            cnt   <= cnt_next;
            cut   <= cut_next;
        end
    end

    // handshake, write path and next owner; the pointer moves only when a grant ends
    always_comb begin
        grant      = {state == GNT1, state == GNT0};
        busy       = state != IDLE;
        req0_ready = (state == GNT0) & ~tx_full;
        req1_ready = (state == GNT1) & ~tx_full;
        xfer       = (req0_ready & req0_valid) | (req1_ready & req1_valid);
        wr_uart    = xfer;
        w_data     = !xfer ? '0 : (state == GNT0) ? req0_data : req1_data;
        own_last   = (state == GNT0) ? req0_last : req1_last;
        at_max     = ({1'b0, cnt} + 9'd1) == 9'(MAX_LEN);
        rel        = xfer & (own_last | at_max);
        cut_next   = rel & ~own_last;
        ptr_next   = rel ? (state == GNT0) : ptr;
        cnt_next   = (state == IDLE) ? 8'd0 : xfer ? cnt + 8'd1 : cnt;
        state_next = rel ? IDLE : state;
        if (state == IDLE)
            state_next = (req0_valid & (~req1_valid | ~ptr)) ? GNT0 : req1_valid ? GNT1 : IDLE;
    end

    assign frame_cut = cut;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a frame-level model
module tb_uart_tx_arbiter;
    localparam int ML = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tx_full, wr_uart, busy, frame_cut;
    logic [7:0] w_data;
    logic [1:0] grant;

    int checks = 0;
    int fails  = 0;

    logic [7:0] q0d[$], q1d[$], wlog[$];
    bit         q0l[$], q1l[$];
    logic [1:0] glog[$];
    int         fc_cnt;
    bit         en0, en1;

    int m_owner;
    bit m_ptr, m_cut;
    int m_len;

    uart_tx_arbiter #(.DBIT(8), .MAX_LEN(ML)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .grant(grant), .busy(busy), .frame_cut(frame_cut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = en0 && q0d.size() != 0;
        req0_data  = q0d.size() != 0 ? q0d[0] : 8'h00;
        req0_last  = q0d.size() != 0 ? q0l[0] : 1'b0;
        req1_valid = en1 && q1d.size() != 0;
        req1_data  = q1d.size() != 0 ? q1d[0] : 8'h00;
        req1_last  = q1d.size() != 0 ? q1l[0] : 1'b0;
    endtask

    task automatic push0(input logic [7:0] d, input bit l);
        q0d.push_back(d);
        q0l.push_back(l);
    endtask

    task automatic push1(input logic [7:0] d, input bit l);
        q1d.push_back(d);
        q1l.push_back(l);
    endtask

    task automatic add_frame(input int who);
        int n;
        n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) begin
            if (who == 0) push0(8'($urandom), i == n - 1 && $urandom % 4 != 0);
            else          push1(8'($urandom), i == n - 1 && $urandom % 4 != 0);
        end
    endtask

    // one clock: check outputs before the edge, advance the model, then let requesters react
    task automatic cycle();
        bit xf, l, p0, p1;
        logic [7:0] d;
        int own;
        @(negedge clk);
        own = m_owner;
        xf  = !tx_full && ((own == 1 && req0_valid) || (own == 2 && req1_valid));
        d   = own == 1 ? req0_data : req1_data;
        l   = own == 1 ? req0_last : req1_last;
        chk("grant", 32'(grant), own == 1 ? 32'd1 : own == 2 ? 32'd2 : 32'd0);
        chk("busy", 32'(busy), 32'(own != 0));
        chk("ready0", 32'(req0_ready), 32'(own == 1 && !tx_full));
        chk("ready1", 32'(req1_ready), 32'(own == 2 && !tx_full));
        chk("wr_uart", 32'(wr_uart), 32'(xf));
        chk("w_data", 32'(w_data), xf ? 32'(d) : 32'd0);
        chk("frame_cut", 32'(frame_cut), 32'(m_cut));
        glog.push_back(grant);
        if (wr_uart) wlog.push_back(w_data);
        if (frame_cut) fc_cnt++;
        m_cut = 0;
        p0 = 0;
        p1 = 0;
        if (own == 0) begin
            m_len   = 0;
            m_owner = (req0_valid && (!req1_valid || !m_ptr)) ? 1 : req1_valid ? 2 : 0;
        end else if (xf) begin
            p0 = own == 1;
            p1 = own == 2;
            m_len++;
            if (l || m_len == ML) begin
                m_cut   = !l;
                m_ptr   = own == 1;
                m_owner = 0;
            end
        end
        @(posedge clk);
        #1;
        if (p0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); end
        if (p1) begin void'(q1d.pop_front()); void'(q1l.pop_front()); end
        drive();
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wr"}, 32'(wr_uart), 32'd0);
        chk({tag, "_wdata"}, 32'(w_data), 32'd0);
        chk({tag, "_rdy"}, 32'({req1_ready, req0_ready}), 32'd0);
        chk({tag, "_cut"}, 32'(frame_cut), 32'd0);
        q0d.delete(); q0l.delete(); q1d.delete(); q1l.delete();
        wlog.delete(); glog.delete();
        fc_cnt = 0; en0 = 1; en1 = 1; tx_full = 1'b0;
        m_owner = 0; m_ptr = 0; m_cut = 0; m_len = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        en0 = 1; en1 = 1; tx_full = 1'b0;
        drive();
        do_reset("rst");

        // both valid from reset: req0 frame first, one idle cycle, then req1
        push0(8'hA1, 0); push0(8'hA2, 1); push1(8'hB1, 1);
        drive();
        repeat (7) cycle();
        chk("r18_n", wlog.size(), 3);
        chk("r18_w0", 32'(wlog[0]), 32'hA1);
        chk("r18_w1", 32'(wlog[1]), 32'hA2);
        chk("r18_w2", 32'(wlog[2]), 32'hB1);
        chk("r18_g", 32'({glog[0], glog[1], glog[2], glog[3], glog[4], glog[5]}), 32'b00_01_01_00_10_00);

        // lone req1 wins with pointer at 0; afterwards req0 is still favoured
        do_reset("rst19");
        push1(8'h31, 0); push1(8'h32, 0); push1(8'h33, 1);
        drive();
        repeat (6) cycle();
        chk("r19_n", wlog.size(), 3);
        chk("r19_g1", 32'(glog[1]), 32'd2);
        push0(8'h40, 1); push1(8'h41, 1);
        drive();
        repeat (2) cycle();
        chk("r19_ptr", 32'(glog[glog.size() - 1]), 32'd1);

        // frame cut at MAX_LEN hands the bus to req1, then req0 resumes
        do_reset("rst20");
        for (int i = 0; i < 6; i++) push0(8'(8'h10 + i), 0);
        push1(8'hB0, 1);
        drive();
        repeat (12) cycle();
        chk("r20_n", wlog.size(), 7);
        chk("r20_w3", 32'(wlog[3]), 32'h13);
        chk("r20_w4", 32'(wlog[4]), 32'hB0);
        chk("r20_w6", 32'(wlog[6]), 32'h15);
        chk("r20_cuts", fc_cnt, 1);
        chk("r20_hold", 32'(grant), 32'd1);

        // FIFO full stalls the grant without writing
        do_reset("rst21");
        push0(8'h11, 0); push0(8'h5A, 0); push0(8'h22, 1);
        drive();
        repeat (2) cycle();
        tx_full = 1'b1;
        repeat (5) cycle();
        chk("r21_stall", wlog.size(), 1);
        tx_full = 1'b0;
        cycle();
        chk("r21_n", wlog.size(), 2);
        chk("r21_w", 32'(wlog[1]), 32'h5A);
        repeat (2) cycle();

        // reset mid-frame in GNT1 abandons the frame; req0 wins afterwards
        do_reset("rst22a");
        push1(8'hC1, 0); push1(8'hC2, 0); push1(8'hC3, 1);
        drive();
        repeat (2) cycle();
        chk("r22_pre", 32'(grant), 32'd2);
        do_reset("r22");
        push0(8'hD0, 1); push1(8'hE0, 1);
        drive();
        repeat (2) cycle();
        chk("r22_g", 32'(glog[1]), 32'd1);
        chk("r22_w", 32'(wlog[0]), 32'hD0);

        // owner drops valid mid-frame: grant held, waiting req1 never written
        do_reset("rst23");
        push0(8'h61, 0); push0(8'h62, 0); push0(8'h63, 1); push1(8'h70, 1);
        drive();
        repeat (2) cycle();
        en0 = 0;
        drive();
        repeat (10) cycle();
        chk("r23_n", wlog.size(), 1);
        chk("r23_g", 32'(grant), 32'd1);
        en0 = 1;
        drive();
        repeat (5) cycle();
        chk("r23_all", wlog.size(), 4);
        chk("r23_b", 32'(wlog[3]), 32'h70);

        // randomized traffic
        do_reset("rst_rand");
        for (int c = 0; c < 2000; c++) begin
            if (q0d.size() == 0 && $urandom % 4 == 0) add_frame(0);
            if (q1d.size() == 0 && $urandom % 4 == 0) add_frame(1);
            en0 = $urandom % 8 != 0;
            en1 = $urandom % 8 != 0;
            tx_full = $urandom % 4 == 0;
            drive();
            cycle();
        end
        chk("rand_progress", 32'(wlog.size() > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
